// File: rtl/axis_lfsr_sched_pkg.sv
// Shared definitions for the AXI-Stream burst scheduler: FSM state encoding.
package axis_lfsr_sched_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BURST = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

endpackage

// File: rtl/axis_lfsr_sched.sv
// Burst scheduler: gates a free-running AXI-Stream source into cfg_num bursts
// of cfg_len words separated by cfg_gap idle cycles, with tlast on each
// burst's final word. Pass-through is purely combinational (no buffering).
module axis_lfsr_sched
   import axis_lfsr_sched_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 64,
   parameter int CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [CNTR_WIDTH-1:0]       cfg_len,
   input  logic [CNTR_WIDTH-1:0]       cfg_gap,
   input  logic [CNTR_WIDTH-1:0]       cfg_num,
   input  logic                        start,
   input  logic                        abort,
   output logic                        busy,
   output logic                        done,
   output logic [CNTR_WIDTH-1:0]       sts_words,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast
);

   localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

   logic [1:0]            state_q, state_d;
   logic [CNTR_WIDTH-1:0] wcnt_q, wcnt_d;
   logic [CNTR_WIDTH-1:0] bcnt_q, bcnt_d;
   logic [CNTR_WIDTH-1:0] gcnt_q, gcnt_d;
   logic [CNTR_WIDTH-1:0] len_q, len_d;
   logic [CNTR_WIDTH-1:0] gap_q, gap_d;
   logic [CNTR_WIDTH-1:0] num_q, num_d;
   logic [CNTR_WIDTH-1:0] sts_words_q, sts_words_d;
   logic                  done_q, done_d;

   logic en;
   logic xfer;
   logic last;

   // Stream gating: abort blocks the handshake in the very cycle it is seen.
   assign en            = (state_q == BURST) & ~abort;
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tvalid = s_axis_tvalid & en;
   assign s_axis_tready = m_axis_tready & en;
   assign last          = en & (wcnt_q == (len_q - ONE));
   assign m_axis_tlast  = last;
   assign xfer          = m_axis_tvalid & m_axis_tready;

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign sts_words = sts_words_q;

   // Next-state logic for the FSM, the three counters and latched config.
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      bcnt_d      = bcnt_q;
      gcnt_d      = gcnt_q;
      len_d       = len_q;
      gap_d       = gap_q;
      num_d       = num_q;
      sts_words_d = sts_words_q;
      done_d      = 1'b0;

      if (abort) begin
         // Abort overrides everything, including a same-cycle start.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  sts_words_d = '0;
                  if (cfg_len != '0) begin
                     len_d   = cfg_len;
                     gap_d   = cfg_gap;
                     num_d   = cfg_num;
                     wcnt_d  = '0;
                     bcnt_d  = '0;
                     gcnt_d  = '0;
                     state_d = BURST;
                  end else begin
                     // Zero-length request completes immediately.
                     done_d = 1'b1;
                  end
               end
            end
            BURST: begin
               if (xfer) begin
                  sts_words_d = sts_words_q + ONE;
                  if (last) begin
                     wcnt_d = '0;
                     bcnt_d = bcnt_q + ONE;
                     if ((num_q != '0) && (bcnt_q == (num_q - ONE))) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end else if (gap_q != '0) begin
                        state_d = GAP;
                     end
                  end else begin
                     wcnt_d = wcnt_q + ONE;
                  end
               end
            end
            GAP: begin
               if (gcnt_q == (gap_q - ONE)) begin
                  gcnt_d  = '0;
                  state_d = BURST;
               end else begin
                  gcnt_d = gcnt_q + ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and counter registers with asynchronous active-low reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         bcnt_q      <= '0;
         gcnt_q      <= '0;
         len_q       <= '0;
         gap_q       <= '0;
         num_q       <= '0;
         sts_words_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         bcnt_q      <= bcnt_d;
         gcnt_q      <= gcnt_d;
         len_q       <= len_d;
         gap_q       <= gap_d;
         num_q       <= num_d;
         sts_words_q <= sts_words_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: doc/axis_lfsr_sched.md
# axis_lfsr_sched

Burst scheduler placed between the PRBS/LFSR stream generator and its downstream consumer (DAC path, DMA writer or loopback checker). It gates the free-running generator stream into `cfg_num` bursts of `cfg_len` words separated by `cfg_gap` idle cycles, and marks burst ends with `tlast`. It also reports progress to the status register bank. Software arms it with a `start` pulse and can cancel it with `abort`.

## Interface
- `AXIS_TDATA_WIDTH`, 64, stream data width.
- `CNTR_WIDTH`, 32, width of all config fields and counters.

- `aclk`  in  1  system clock; all logic on rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `cfg_len`  in  CNTR_WIDTH  words per burst; latched at start.
- `cfg_gap`  in  CNTR_WIDTH  idle cycles between bursts; latched at start.
- `cfg_num`  in  CNTR_WIDTH  burst count; 0 means continuous; latched at start.
- `start`  in  1  single-cycle arm request.
- `abort`  in  1  cancel request.
- `busy`  out  1  high while a sequence runs.
- `done`  out  1  one-cycle pulse on normal completion.
- `sts_words`  out  CNTR_WIDTH  words delivered since last accepted start.
- `s_axis_tready`  out  1  upstream ready.
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  upstream data.
- `s_axis_tvalid`  in  1  upstream valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  equals `s_axis_tdata`.
- `m_axis_tvalid`  out  1  downstream valid.
- `m_axis_tlast`  out  1  last word of a burst.

## Operation
- **States:** IDLE, BURST, GAP.
- **Counters:** word (`wcnt`), burst (`bcnt`), gap (`gcnt`).
- **Pass-through gating, combinational, zero latency.** Define `en = (state==BURST) & ~abort`.
  - `m_axis_tvalid = s_axis_tvalid & en`.
  - `s_axis_tready = m_axis_tready & en`.
  - Handshake `xfer = m_axis_tvalid & m_axis_tready`.
- **Flow control:** no buffering. Upstream stalls propagate downstream and downstream stalls propagate upstream.
- **IDLE:**
  - `start` with `cfg_len != 0`: latch config, clear `wcnt`/`bcnt`/`gcnt`/`sts_words`, go to BURST.
  - `start` with `cfg_len == 0`: pulse `done`, stay in IDLE, `sts_words` cleared.
- **BURST:**
  - Each `xfer`: `wcnt++`, `sts_words++` (wraps modulo 2^CNTR_WIDTH).
  - `m_axis_tlast = en & (wcnt == len-1)`.
  - On `xfer` with tlast: `wcnt = 0`, `bcnt++`.
    - If `num != 0 && bcnt == num-1`: go to IDLE and pulse `done`.
    - Else if `gap == 0`: stay in BURST.
    - Else: go to GAP.
- **GAP:** `gcnt++` each cycle. When `gcnt == gap-1`: `gcnt = 0`, go to BURST.
- **Continuous mode (`num == 0`):** runs until abort. `bcnt` wraps without effect.
- **`abort`:**
  - Highest priority, in any state.
  - Gates the stream in the same cycle, so no `xfer` occurs.
  - Next state is IDLE; `done` is not pulsed.
  - `sts_words` holds its value.
- **`start` and `abort` in the same cycle in IDLE:** abort wins; start is ignored.
- **`start` while busy:** ignored.
- **Config changes while busy:** no effect; latched copies are used.

## Timing
- **Reset values:** state IDLE; counters 0; `busy`, `done`, `m_axis_tvalid`, `m_axis_tlast`, `s_axis_tready` all 0; `sts_words` 0. `m_axis_tdata` follows the input.
- **Start:** `busy` rises the cycle after an accepted `start`. The first word may transfer in that same cycle.
- **Completion:** `done` is high for one cycle, the cycle after the final `xfer`; `busy` falls in that same cycle.
- **Gap:** exactly `cfg_gap` cycles with `m_axis_tvalid` low between a burst's final `xfer` and the next BURST cycle.
- **Burst length:** independent of stalls. Each burst contains exactly `cfg_len` handshakes.
- **Async reset mid-burst:** all outputs drop to reset values immediately; no `done`.

## Structure
- **Shared package/include `axis_lfsr_sched_pkg`:** holds the state-encoding localparams (IDLE=2'd0, BURST=2'd1, GAP=2'd2).
- **No sub-module:** the FSM, the three counters and the combinational gating live in one module.
- **Bench:** instantiates the existing LFSR generator with tready handling enabled as the upstream source.

## Test plan
- **Single burst, no backpressure:** `cfg_len=4`, `cfg_gap=0`, `cfg_num=1`, start → 4 consecutive transfers, tlast on the 4th, `done` the next cycle, `sts_words=4`.
- **Gap spacing:** `cfg_len=2`, `cfg_gap=3`, `cfg_num=3` → pattern VV___VV___VV, done after 6 words, `sts_words=6`.
- **Random tready stalls:** `cfg_len=5`, `cfg_num=2` → exactly 10 handshakes and data equal to the LFSR sequence with no word lost or repeated.
- **Continuous mode and abort:** `cfg_num=0`, `cfg_len=3`, abort asserted after 7 words → `m_axis_tvalid` low in the abort cycle, IDLE next cycle, no `done`, `sts_words=7`.
- **Zero length:** `cfg_len=0`, start → `done` pulse, `busy` never rises, no transfers.
- **Reset mid-burst:** `aresetn` low during word 2 → all outputs 0 asynchronously. A subsequent start with `cfg_len=4`, `cfg_num=1` behaves as a fresh run.
